commit_trace_rx: RTL
====================

// Module: commit_trace_rx
// PURPOSE
//  Receiving end of the core's retirement stream (update/pc/data).
//  - Captures each retire pulse as a tagged entry in an on-chip FIFO.
//  - Drains entries to a checker/logger over a valid/ready port.
//  - Counts retirements and drops.
//  - Freezes capture on a programmable stop PC.
//  Sits beside core_model in system benches and in debug builds.
// PARAMETERS
//  DEPTH   16   FIFO entries; power of two, >=2
//  SEQW    16   width of per-retirement sequence tag (wraps)
//  CNTW    32   width of retire and drop counters (saturating)
// PORTS
//  clk_i          in   1      clock, all logic on rising edge
//  rstn_i         in   1      synchronous reset, active-low
//  update_i       in   1      retire pulse from core (update_o)
//  pc_i           in   XLEN   retired PC (core pc_o)
//  data_i         in   XLEN   retire data (core data_o)
//  enable_i       in   1      capture enable
//  clear_i        in   1      sync flush: FIFO, counters, stop state
//  stop_pc_en_i   in   1      arm stop-on-PC
//  stop_pc_i      in   XLEN   stop PC value
//  m_valid_o      out  1      head entry valid
//  m_ready_i      in   1      consumer accepts head
//  m_entry_o      out  entry  head entry {seq, pc, data}
//  level_o        out  $clog2(DEPTH)+1   FIFO occupancy
//  retire_cnt_o   out  CNTW   retirements seen while capturing
//  drop_cnt_o     out  CNTW   retirements lost to full FIFO
//  stopped_o      out  1      capture frozen by stop PC
// BEHAVIOUR
//  Reset (rstn_i==0 at edge): FSM=IDLE, pointers/level=0, seq=0, counters=0.
//   m_valid_o=0, stopped_o=0, m_entry_o=0. Mid-operation reset discards all entries.
//  FSM:
//   IDLE->CAPTURE when enable_i=1.
//   CAPTURE->IDLE when enable_i=0.
//   CAPTURE->STOPPED when a retire with stop_pc_en_i=1 and pc_i==stop_pc_i is seen.
//   STOPPED->IDLE only on clear_i or reset.
//  Retire event (ev): update_i=1 while FSM==CAPTURE.
//   - Each ev takes tag seq, then seq<=seq+1 (mod 2^SEQW).
//   - Each ev increments retire_cnt (saturates at all-ones).
//   - Drops still consume a tag, so gaps in seq expose drops.
//  Push: ev and (not full or pop in same cycle).
//   - ev while full and no pop: entry dropped, drop_cnt+1 (saturating).
//  Pop: m_valid_o & m_ready_i. Full+push+pop in one cycle: both occur, level unchanged.
//  Stop-PC entry is pushed (or dropped) like any ev. stopped_o=1 from the next cycle.
//   Later update_i pulses are ignored (no seq/counter change).
//  Latency: push at edge N -> m_valid_o=1 after edge N if FIFO was empty. Show-ahead head.
//  m_valid_o = level!=0; m_entry_o stable while m_valid_o & !m_ready_i.
//  Pointers wrap mod DEPTH; level distinguishes full from empty.
//  clear_i has priority over push/pop in the same cycle:
//   - zeroes pointers, seq and counters.
//   - returns FSM to IDLE (CAPTURE next cycle if enable_i=1).
//  enable_i deassert does not flush; the consumer may keep draining.
// STRUCTURE
//  riscv_pkg: XLEN (existing).
//   Add typedef trace_entry_t = packed struct {logic [SEQW-1:0] seq; pc; data}
//   with SEQW as a package localparam (default 16).
//   Add enum trace_state_e {IDLE, CAPTURE, STOPPED}.
//  Sub-module sync_fifo #(WIDTH,DEPTH):
//   - ports push/pop/wdata/rdata/level/full/empty, same clk_i/rstn_i/clear.
//   - reusable for later trace sinks.
//  Top holds the FSM, seq generator, stop compare, saturating counters.
// TESTING
//  1. Reset; enable; 3 retires pc=0,4,8 with m_ready=1 -> seq 0,1,2 in order. retire_cnt=3, level back to 0.
//  2. m_ready=0; DEPTH+2 retires -> level=DEPTH, drop_cnt=2. Drain shows seq 0..DEPTH-1; next seq tag = DEPTH+2.
//  3. FIFO full; update_i & m_ready_i in one cycle -> no drop, level stays DEPTH, new entry lands at tail.
//  4. stop_pc=0x10 armed; retires 0x8,0x10,0x14 -> 0x10 captured, stopped_o=1. 0x14 ignored, retire_cnt=2.
//  5. clear_i while FIFO holds 5 and update_i=1 -> level=0, seq=0, counters 0, stopped_o=0, no push.
//  6. Reset asserted with 4 queued and m_valid=1 -> next cycle m_valid_o=0, all counters 0, FSM IDLE.

Source files
------------

// File: rtl/commit_trace_rx_pkg.sv
// rtl/commit_trace_rx_pkg.sv - shared types for the commit trace receiver
// Purpose: XLEN, sequence tag width, trace entry layout and FSM state encoding.
package commit_trace_rx_pkg;

    localparam int XLEN = 32;
    localparam int SEQW = 16;

    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STOPPED = 2'd2
    } trace_state_e;

endpackage

// File: rtl/commit_trace_rx_if.sv
// rtl/commit_trace_rx_if.sv - valid/ready trace entry port
// Purpose: carries the FIFO head entry to the checker/logger.
// Ports: valid (head entry present), ready (consumer accepts), entry {seq, pc, data}.
interface commit_trace_rx_if;
    import commit_trace_rx_pkg::*;

    logic         valid;
    logic         ready;
    trace_entry_t entry;

    modport master (output valid, output entry, input ready);
    modport slave  (input valid, input entry, output ready);
endinterface

// File: rtl/commit_trace_rx_sync_fifo.sv
// rtl/commit_trace_rx_sync_fifo.sv - show-ahead synchronous FIFO
// Purpose: generic storage for trace sinks; head word visible on rdata_o while not empty.
// Ports: clk_i, rstn_i (sync, active-low), clear_i (sync flush), push_i, pop_i,
//        wdata_i, rdata_o (zero when empty), level_o, full_o, empty_o.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i) & ~clear_i;
    assign pop_ok  = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: rdata_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/commit_trace_rx.sv
// rtl/commit_trace_rx.sv - receiver for the core retirement stream
// Purpose: tags each retire with a sequence number, queues it, drains over m_if,
//          counts retirements and drops, freezes capture on a stop PC.
// Ports: clk_i, rstn_i (sync, active-low); update_i/pc_i/data_i retire input;
//        enable_i, clear_i, stop_pc_en_i, stop_pc_i control; m_if head entry port;
//        level_o, retire_cnt_o, drop_cnt_o, stopped_o status.
module commit_trace_rx
    import commit_trace_rx_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CNTW  = 32,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  update_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  stop_pc_en_i,
    input  logic [XLEN-1:0]       stop_pc_i,
    commit_trace_rx_if.master     m_if,
    output logic [LW-1:0]         level_o,
    output logic [CNTW-1:0]       retire_cnt_o,
    output logic [CNTW-1:0]       drop_cnt_o,
    output logic                  stopped_o
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_STOPPED = STOPPED;

    logic [1:0]      state_q, state_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic [CNTW-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

    logic         ev, pop, push, drop, stop_hit;
    logic         fifo_full, fifo_empty;
    trace_entry_t wentry;
    logic [$bits(trace_entry_t)-1:0] fifo_rdata;

    assign pop      = m_if.valid & m_if.ready;
    assign ev       = update_i & (state_q == ST_CAPTURE) & ~clear_i;
    assign push     = ev & (~fifo_full | pop);
    assign drop     = ev & fifo_full & ~pop;
    assign stop_hit = ev & stop_pc_en_i & (pc_i == stop_pc_i);

    always_comb begin
        wentry      = '0;
        wentry.seq  = seq_q;
        wentry.pc   = pc_i;
        wentry.data = data_i;
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        retire_cnt_d = retire_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (clear_i) begin
            state_d      = ST_IDLE;
            seq_d        = '0;
            retire_cnt_d = '0;
            drop_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE:    if (enable_i) state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (stop_hit)       state_d = ST_STOPPED;
                    else if (!enable_i) state_d = ST_IDLE;
                end
                ST_STOPPED: state_d = ST_STOPPED;
                default:    state_d = ST_IDLE;
            endcase
            // Dropped retires still consume a tag so gaps reveal losses.
            if (ev) begin
                seq_d = seq_q + SEQW'(1);
                if (~&retire_cnt_q) retire_cnt_d = retire_cnt_q + CNTW'(1);
            end
            if (drop && ~&drop_cnt_q) drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (fifo_rdata),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_if.valid   = ~fifo_empty;
    assign m_if.entry   = trace_entry_t'(fifo_rdata);
    assign retire_cnt_o = retire_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign stopped_o    = (state_q == ST_STOPPED);

endmodule
